sr_drive_ctrl: RTL and testbench

SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

---
 rtl/sr_drv_pkg.sv | 20 ++
 rtl/sr_drive_ctrl.sv | 106 ++++++++++
 tb/tb_sr_drive_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sr_drv_pkg.sv
// Shared SR command codes, counter width and FSM state type for the SR flip-flop drive controller.
package sr_drv_pkg;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_CLR  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StGap
  } drv_state_e;

  function automatic logic [1:0] op_code(input logic op);
    return op ? SR_SET : SR_CLR;
  endfunction

endpackage

// File: rtl/sr_drive_ctrl.sv
// Drives set/clear pulses of HOLD_CYC cycles plus GAP_CYC hold cycles into an SR flip-flop.
// Optional macro SR_DRV_SKIP_REDUNDANT_EN: commands matching q_exp are acknowledged without a drive.
module sr_drive_ctrl
  import sr_drv_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned GAP_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_op,
  output logic       req_ready,
  output logic [1:0] sr,
  output logic       q_exp,
  output logic       busy
);

  localparam logic [CntW-1:0] HoldLd = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] GapLd  = CntW'(GAP_CYC - 1);

  drv_state_e      r_state, w_state_d;
  logic            r_op, w_op_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_q_exp, w_q_exp_d;
  logic [1:0]      r_sr, w_sr_d;
  logic            r_busy, w_busy_d;
  logic            w_accept, w_skip;

  assign req_ready = (r_state == StIdle);
  assign w_accept  = req_valid & req_ready;

`ifdef SR_DRV_SKIP_REDUNDANT_EN
  assign w_skip = (req_op == r_q_exp);
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_op_d    = r_op;
    w_cnt_d   = r_cnt;
    w_q_exp_d = r_q_exp;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_q_exp_d = req_op;
          if (!w_skip) begin
            w_state_d = StDrive;
            w_op_d    = req_op;
            w_cnt_d   = HoldLd;
          end
        end
      end
      StDrive: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - 1'b1;
        end else if (GAP_CYC != 0) begin
          w_state_d = StGap;
          w_cnt_d   = GapLd;
        end else begin
          w_state_d = StIdle;
        end
      end
      StGap: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - 1'b1;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered without adding latency.
  always_comb begin
    w_sr_d   = (w_state_d == StDrive) ? op_code(w_op_d) : SR_HOLD;
    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_op    <= 1'b0;
      r_cnt   <= '0;
      r_q_exp <= 1'b0;
      r_sr    <= SR_HOLD;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_op    <= w_op_d;
      r_cnt   <= w_cnt_d;
      r_q_exp <= w_q_exp_d;
      r_sr    <= w_sr_d;
      r_busy  <= w_busy_d;
    end
  end

  assign sr    = r_sr;
  assign q_exp = r_q_exp;
  assign busy  = r_busy;

  sr_never_both_a: assert property (@(posedge clk) disable iff (!rst_n) sr != (SR_SET | SR_CLR));

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Self-checking bench: two configurations (2/1 and 1/0) each run directed and random
// requests against a schedule-queue reference model plus a downstream SR flip-flop.
module tb_sr_drive_ctrl;

  logic clk = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int unsigned H = (g == 0) ? 2 : 1;
    localparam int unsigned G = (g == 0) ? 1 : 0;

    logic       rst_n;
    logic       req_valid = 1'b0;
    logic       req_op = 1'b0;
    logic       req_ready, q_exp, busy;
    logic [1:0] sr;
    logic       ff_q;

    // Reference model: each accepted command appends its per-cycle sr codes to a queue.
    logic [1:0] sched [$];
    logic [1:0] m_sr = 2'b00;
    logic       m_busy = 1'b0;
    logic       m_q_exp = 1'b0;
    bit         d_acc = 1'b0;
    bit         redundant = 1'b0;
    bit         have_last = 1'b0;
    bit         held = 1'b0;
    int         cyc = 0;
    int         last_acc = 0;
    int         exp_gap = 0;

    sr_drive_ctrl #(
      .HOLD_CYC(H),
      .GAP_CYC (G)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_op   (req_op),
      .req_ready(req_ready),
      .sr       (sr),
      .q_exp    (q_exp),
      .busy     (busy)
    );

    // Downstream SR flip-flop fed by the DUT's sr output.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff_q <= 1'b0;
      else if (sr == 2'b10) ff_q <= 1'b1;
      else if (sr == 2'b01) ff_q <= 1'b0;
    end

    initial begin
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          sched.delete();
          m_sr = 2'b00;
          m_busy = 1'b0;
          m_q_exp = 1'b0;
          d_acc = 1'b0;
          have_last = 1'b0;
          held = 1'b0;
        end else begin
          cyc++;
          if (req_valid && !m_busy) begin
`ifdef SR_DRV_SKIP_REDUNDANT_EN
            redundant = (req_op == m_q_exp);
`else
            redundant = 1'b0;
`endif
            if (!redundant) begin
              repeat (H) sched.push_back(req_op ? 2'b10 : 2'b01);
              repeat (G) sched.push_back(2'b00);
            end
            m_q_exp = req_op;
          end
          d_acc = req_valid && req_ready;
          if (d_acc) begin
            if (have_last && held)
              check_eq($sformatf("c%0d_spacing", g), cyc - last_acc, exp_gap);
            have_last = 1'b1;
            held = 1'b1;
            last_acc = cyc;
            exp_gap = redundant ? 1 : H + G + 1;
          end else if (!req_valid) begin
            held = 1'b0;
          end
          if (sched.size() > 0) begin
            m_sr = sched.pop_front();
            m_busy = 1'b1;
          end else begin
            m_sr = 2'b00;
            m_busy = 1'b0;
          end
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        check_eq($sformatf("c%0d_sr", g), sr, m_sr);
        check_eq($sformatf("c%0d_busy", g), busy, m_busy);
        check_eq($sformatf("c%0d_ready", g), req_ready, !m_busy);
        check_eq($sformatf("c%0d_q_exp", g), q_exp, m_q_exp);
        if (!m_busy) check_eq($sformatf("c%0d_ff_vs_q_exp", g), ff_q, m_q_exp);
      end
    end

    initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      // Request already pending when reset releases: accepted on the very next edge.
      req_valid = 1'b1;
      req_op = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 20 && !d_acc; i++) @(negedge clk);
      check_eq($sformatf("c%0d_acc_set", g), d_acc, 1);
      req_op = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 20 && !d_acc; i++) @(negedge clk);
      check_eq($sformatf("c%0d_acc_clr", g), d_acc, 1);
      req_valid = 1'b0;
      repeat (H + G + 2) @(negedge clk);

      // Abort a set drive with an asynchronous reset one cycle into it.
      req_valid = 1'b1;
      req_op = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 20 && !d_acc; i++) @(negedge clk);
      check_eq($sformatf("c%0d_acc_rst", g), d_acc, 1);
      req_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq($sformatf("c%0d_rst_async_sr", g), sr, 2'b00);
      check_eq($sformatf("c%0d_rst_async_busy", g), busy, 1'b0);
      check_eq($sformatf("c%0d_rst_async_q_exp", g), q_exp, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int c = 0; c < 250; c++) begin
        @(negedge clk);
        if (!req_valid || d_acc) begin
          req_valid = ($urandom_range(0, 3) != 0);
          req_op = 1'($urandom_range(0, 1));
        end
      end
      req_valid = 1'b0;
    end
  end

  initial begin
    repeat (420) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
